// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter, decode and register file.
package rf_wb_arbiter_pkg;

   localparam int RF_XLEN     = 32;
   localparam int RF_NREG     = 32;
   localparam int RF_AW       = 5;
   localparam int RF_MAX_WAIT = 4;

   // Arbiter state: pipeline has priority, or the multi-cycle unit is being forced through.
   typedef enum logic {
      ST_PIPE   = 1'b0,
      ST_STARVE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for destinations owned by in-flight multi-cycle ops.
// A set and a clear of the same register in one cycle leaves it busy, since the
// new issue owns the register after the old result lands. x0 is never busy.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
#(
   parameter int NREG = RF_NREG,
   parameter int AW   = RF_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_i,
   input  logic [AW-1:0]   set_rd_i,
   input  logic            clr_i,
   input  logic [AW-1:0]   clr_rd_i,
   input  logic [AW-1:0]   q_rs1_i,
   input  logic [AW-1:0]   q_rs2_i,
   input  logic [AW-1:0]   q_rd_i,
   output logic            hit_o,
   output logic [NREG-1:0] busy_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Next busy vector: clear first so a same-cycle set overrides it; bit 0 forced low.
   always_comb begin
      busy_d = busy_q;
      if (clr_i) busy_d[clr_rd_i] = 1'b0;
      if (set_i) busy_d[set_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Busy vector register, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign hit_o  = busy_q[q_rs1_i] | busy_q[q_rs2_i] | busy_q[q_rd_i];
   assign busy_o = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs multi-cycle unit with a
// starvation bound, registered write port, and decode hazard stall.
// Handshake: a transfer happens in a cycle where valid and ready are both high;
// the source holds rd/data stable while valid is high and ready is low. Ready never
// depends on the source's own valid (only on state, p_valid and p_rd).
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREG     = RF_NREG,
   parameter int AW       = RF_AW,
   parameter int MAX_WAIT = RF_MAX_WAIT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p_valid,
   input  logic [AW-1:0]   p_rd,
   input  logic [XLEN-1:0] p_data,
   output logic            p_ready,
   input  logic            m_valid,
   input  logic [AW-1:0]   m_rd,
   input  logic [XLEN-1:0] m_data,
   output logic            m_ready,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   input  logic [AW-1:0]   q_rs1,
   input  logic [AW-1:0]   q_rs2,
   input  logic [AW-1:0]   q_rd,
   output logic            q_stall,
   output logic            rf_we,
   output logic [AW-1:0]   rf_rd_addr,
   output logic [XLEN-1:0] rf_rd_data,
   output arb_state_e      dbg_state,
   output logic [NREG-1:0] dbg_busy
);

   arb_state_e      state_q;
   logic [3:0]      wait_cnt_q;
   logic            rf_we_q;
   logic [AW-1:0]   rf_rd_addr_q;
   logic [XLEN-1:0] rf_rd_data_q;
   logic            p_fire;
   logic            m_fire;
   logic            sb_hit;
   logic            inflight_hit;

   // Ready decode: in ST_PIPE the unit only gets the port when the pipeline does not need it.
   always_comb begin
      p_ready = (state_q == ST_PIPE);
      m_ready = (state_q == ST_STARVE) || !(p_valid && (p_rd != '0));
   end

   assign p_fire = p_valid && p_ready;
   assign m_fire = m_valid && m_ready;

   // Arbiter FSM and starvation counter. ST_STARVE always exits after one cycle since
   // m_ready is high there: either the unit fires or it has dropped valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_PIPE;
         wait_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_PIPE: begin
               if (m_fire || !m_valid) begin
                  wait_cnt_q <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 4'd1;
                  if (wait_cnt_q == 4'(MAX_WAIT)) state_q <= ST_STARVE;
               end
            end
            ST_STARVE: begin
               state_q    <= ST_PIPE;
               wait_cnt_q <= '0;
            end
            default: begin
               state_q    <= ST_PIPE;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   // Write-port register: pipeline wins the mux; fires to x0 are consumed without a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q      <= 1'b0;
         rf_rd_addr_q <= '0;
         rf_rd_data_q <= '0;
      end else begin
         rf_we_q <= 1'b0;
         if (p_fire && (p_rd != '0)) begin
            rf_we_q      <= 1'b1;
            rf_rd_addr_q <= p_rd;
            rf_rd_data_q <= p_data;
         end else if (m_fire && (m_rd != '0)) begin
            rf_we_q      <= 1'b1;
            rf_rd_addr_q <= m_rd;
            rf_rd_data_q <= m_data;
         end
      end
   end

   rf_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_i    (iss_valid),
      .set_rd_i (iss_rd),
      .clr_i    (m_fire),
      .clr_rd_i (m_rd),
      .q_rs1_i  (q_rs1),
      .q_rs2_i  (q_rs2),
      .q_rd_i   (q_rd),
      .hit_o    (sb_hit),
      .busy_o   (dbg_busy)
   );

   // The write sitting in rf_* has not reached the file yet, so its readers must wait a cycle.
   always_comb begin
      inflight_hit = rf_we_q && (rf_rd_addr_q != '0) &&
                     ((rf_rd_addr_q == q_rs1) || (rf_rd_addr_q == q_rs2));
      q_stall      = sb_hit || inflight_hit;
   end

   assign rf_we      = rf_we_q;
   assign rf_rd_addr = rf_rd_addr_q;
   assign rf_rd_data = rf_rd_data_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, pipeline write, contention/starvation,
// x0 sharing, scoreboard stall with in-flight term, set/clear collision, mid-op reset.
module tb_rf_wb_arbiter;
   import rf_wb_arbiter_pkg::*;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            rst;
   logic            p_valid;
   logic [AW-1:0]   p_rd;
   logic [XLEN-1:0] p_data;
   logic            p_ready;
   logic            m_valid;
   logic [AW-1:0]   m_rd;
   logic [XLEN-1:0] m_data;
   logic            m_ready;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic [AW-1:0]   q_rs1;
   logic [AW-1:0]   q_rs2;
   logic [AW-1:0]   q_rd;
   logic            q_stall;
   logic            rf_we;
   logic [AW-1:0]   rf_rd_addr;
   logic [XLEN-1:0] rf_rd_data;
   arb_state_e      dbg_state;
   logic [NREG-1:0] dbg_busy;

   int checks = 0;
   int errors = 0;
   logic [NREG-1:0] exp_busy;

   rf_wb_arbiter #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .AW       (AW),
      .MAX_WAIT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p_valid    (p_valid),
      .p_rd       (p_rd),
      .p_data     (p_data),
      .p_ready    (p_ready),
      .m_valid    (m_valid),
      .m_rd       (m_rd),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .q_rd       (q_rd),
      .q_stall    (q_stall),
      .rf_we      (rf_we),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .dbg_state  (dbg_state),
      .dbg_busy   (dbg_busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; p_valid = 1'b0; p_rd = '0; p_data = '0;
      m_valid = 1'b0; m_rd = '0; m_data = '0;
      iss_valid = 1'b0; iss_rd = '0; q_rs1 = '0; q_rs2 = '0; q_rd = '0;
      exp_busy = '0;
      tick(); tick();
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_we",      64'(rf_we), 64'(0));
      chk("rst_addr",    64'(rf_rd_addr), 64'(0));
      chk("rst_data",    64'(rf_rd_data), 64'(0));
      chk("rst_p_ready", 64'(p_ready), 64'(1));
      chk("rst_m_ready", 64'(m_ready), 64'(1));
      chk("rst_stall",   64'(q_stall), 64'(0));
      chk("rst_busy",    64'(dbg_busy), 64'(0));
      chk("rst_state",   64'(dbg_state), 64'(ST_PIPE));

      // Pipeline only
      p_valid = 1'b1; p_rd = 5'd5; p_data = 32'hDEADBEEF;
      #1;
      chk("pipe_p_ready", 64'(p_ready), 64'(1));
      chk("pipe_m_ready", 64'(m_ready), 64'(0));
      tick();
      p_valid = 1'b0;
      chk("pipe_we",   64'(rf_we), 64'(1));
      chk("pipe_addr", 64'(rf_rd_addr), 64'(5));
      chk("pipe_data", 64'(rf_rd_data), 64'(32'hDEADBEEF));
      tick();
      chk("pipe_we_drop", 64'(rf_we), 64'(0));

      // Contention: m loses 5 cycles, then is forced through
      m_valid = 1'b1; m_rd = 5'd7; m_data = 32'h0000_0777;
      p_valid = 1'b1; p_rd = 5'd1; p_data = 32'h1000_0000;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("cont_m_blocked", 64'(m_ready), 64'(0));
         chk("cont_p_ready",   64'(p_ready), 64'(1));
         tick();
         chk("cont_p_addr", 64'(rf_rd_addr), 64'(i + 1));
         chk("cont_p_data", 64'(rf_rd_data), 64'(32'h1000_0000 + i));
         p_rd = 5'(i + 2); p_data = 32'h1000_0001 + 32'(i);
         #1;
      end
      chk("starve_state",   64'(dbg_state), 64'(ST_STARVE));
      chk("starve_p_ready", 64'(p_ready), 64'(0));
      chk("starve_m_ready", 64'(m_ready), 64'(1));
      tick();
      chk("starve_we",      64'(rf_we), 64'(1));
      chk("starve_addr",    64'(rf_rd_addr), 64'(7));
      chk("starve_data",    64'(rf_rd_data), 64'(32'h0000_0777));
      chk("starve_p_back",  64'(p_ready), 64'(1));
      chk("starve_exit",    64'(dbg_state), 64'(ST_PIPE));
      m_valid = 1'b0; p_valid = 1'b0;
      tick();

      // x0 sharing: both fire, only m writes
      p_valid = 1'b1; p_rd = 5'd0; p_data = 32'h1111_1111;
      m_valid = 1'b1; m_rd = 5'd9; m_data = 32'h9999_0009;
      #1;
      chk("x0_p_ready", 64'(p_ready), 64'(1));
      chk("x0_m_ready", 64'(m_ready), 64'(1));
      tick();
      p_valid = 1'b0; m_valid = 1'b0;
      chk("x0_we",   64'(rf_we), 64'(1));
      chk("x0_addr", 64'(rf_rd_addr), 64'(9));
      chk("x0_data", 64'(rf_rd_data), 64'(32'h9999_0009));
      tick();
      chk("x0_we_drop", 64'(rf_we), 64'(0));

      // Scoreboard: issue to x3, dependent read stalls until the result plus one cycle
      iss_valid = 1'b1; iss_rd = 5'd3;
      tick();
      iss_valid = 1'b0;
      exp_busy[3] = 1'b1;
      q_rs1 = 5'd3;
      #1;
      chk("sb_busy_set", 64'(dbg_busy), 64'(exp_busy));
      chk("sb_stall_1",  64'(q_stall), 64'(1));
      tick();
      chk("sb_stall_2",  64'(q_stall), 64'(1));
      m_valid = 1'b1; m_rd = 5'd3; m_data = 32'h0000_0033;
      #1;
      chk("sb_stall_fire", 64'(q_stall), 64'(1));
      tick();
      m_valid = 1'b0;
      exp_busy[3] = 1'b0;
      #1;
      chk("sb_busy_clr",     64'(dbg_busy), 64'(exp_busy));
      chk("sb_inflight_we",  64'(rf_we), 64'(1));
      chk("sb_stall_flight", 64'(q_stall), 64'(1));
      q_rs1 = 5'd0; q_rs2 = 5'd3;
      #1;
      chk("sb_stall_rs2_flight", 64'(q_stall), 64'(1));
      tick();
      chk("sb_stall_done", 64'(q_stall), 64'(0));
      q_rs2 = 5'd0;

      // Destination-port hazard and x0 issue
      iss_valid = 1'b1; iss_rd = 5'd4;
      tick();
      iss_rd = 5'd0;
      exp_busy[4] = 1'b1;
      q_rd = 5'd4;
      #1;
      chk("sb_rd_stall", 64'(q_stall), 64'(1));
      tick();
      iss_valid = 1'b0;
      q_rd = 5'd0;
      #1;
      chk("sb_x0_never_busy", 64'(dbg_busy), 64'(exp_busy));
      chk("sb_q_x0_stall",    64'(q_stall), 64'(0));

      // Set/clear collision on x3: set wins
      iss_valid = 1'b1; iss_rd = 5'd3;
      m_valid = 1'b1; m_rd = 5'd3; m_data = 32'h0000_3333;
      #1;
      chk("coll_m_ready", 64'(m_ready), 64'(1));
      tick();
      iss_valid = 1'b0; m_valid = 1'b0;
      exp_busy[3] = 1'b1;
      chk("coll_busy", 64'(dbg_busy), 64'(exp_busy));
      chk("coll_addr", 64'(rf_rd_addr), 64'(3));

      // Reset mid-operation with a write pending and busy bits set
      p_valid = 1'b1; p_rd = 5'd6; p_data = 32'hCAFE_0006;
      tick();
      p_valid = 1'b0;
      chk("mid_we_before", 64'(rf_we), 64'(1));
      #3;
      rst = 1'b1;
      #1;
      exp_busy = '0;
      chk("mid_rst_we",      64'(rf_we), 64'(0));
      chk("mid_rst_busy",    64'(dbg_busy), 64'(exp_busy));
      chk("mid_rst_p_ready", 64'(p_ready), 64'(1));
      chk("mid_rst_stall",   64'(q_stall), 64'(0));
      tick();
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
